// File: rtl/axi_read_arbiter_pkg.sv
// Shared definitions for the IFU/MEM single-beat AXI read arbiter.
package axi_read_arbiter_pkg;

    // FSM state encoding (plain constants so older tools and netlists keep the same codes)
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t IDLE = 2'd0;
    localparam arb_state_t AR   = 2'd1;
    localparam arb_state_t R    = 2'd2;
    localparam arb_state_t RESP = 2'd3;

    // Which master owns the transaction in flight
    typedef logic owner_t;
    localparam owner_t OWNER_MEM = 1'b0;
    localparam owner_t OWNER_IFU = 1'b1;

    // AXI constants
    localparam logic [1:0] AXI_OKAY       = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'h00;

    // A single-beat response is bad if it is not OKAY, carries someone else's id,
    // or is not flagged as the last beat.
    function automatic logic beat_is_bad(input logic [1:0] resp,
                                         input logic [3:0] rid,
                                         input logic [3:0] exp_id,
                                         input logic       last);
        return (resp != AXI_OKAY) | (rid != exp_id) | !last;
    endfunction

endpackage

// File: rtl/axi_read_arbiter.sv
// Arbitrates single-beat reads from IFU and MEM onto one AXI AR/R channel.
// One transaction in flight at a time; MEM has fixed priority.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request; accept MEM first, else IFU
// AR    | arvalid high with latched addr/size/id until arready
// R     | rready high; capture the single beat and its error status
// RESP  | present buffered beat to the owner until it takes it
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter logic [3:0] ARID_MEM = 4'd0,
    parameter logic [3:0] ARID_IFU = 4'd1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] ARBITER_IFU_raddr,
    input  logic [2:0]  ARBITER_IFU_rsize,
    input  logic        ARBITER_IFU_raddr_valid,
    output logic        ARBITER_IFU_raddr_ready,
    output logic [63:0] ARBITER_IFU_rdata,
    output logic        ARBITER_IFU_rdata_valid,
    input  logic        ARBITER_IFU_rdata_ready,

    input  logic [31:0] ARBITER_MEM_raddr,
    input  logic [2:0]  ARBITER_MEM_rsize,
    input  logic        ARBITER_MEM_raddr_valid,
    output logic        ARBITER_MEM_raddr_ready,
    output logic [63:0] ARBITER_MEM_rdata,
    output logic        ARBITER_MEM_rdata_valid,
    input  logic        ARBITER_MEM_rdata_ready,

    input  logic        io_master_arready,
    output logic        io_master_arvalid,
    output logic [31:0] io_master_araddr,
    output logic [3:0]  io_master_arid,
    output logic [7:0]  io_master_arlen,
    output logic [2:0]  io_master_arsize,
    output logic [1:0]  io_master_arburst,
    output logic        io_master_rready,
    input  logic        io_master_rvalid,
    input  logic [63:0] io_master_rdata,
    input  logic [1:0]  io_master_rresp,
    input  logic        io_master_rlast,
    input  logic [3:0]  io_master_rid,

    output logic        ARBITER_error_signal
);

    arb_state_t  state;
    arb_state_t  state_nxt;
    owner_t      owner;
    logic [31:0] addr_lat;
    logic [2:0]  size_lat;
    logic [63:0] beat_buf;
    logic        err_flag;

    logic        accept_mem;
    logic        accept_ifu;
    logic        owner_rdata_ready;
    logic [3:0]  owner_id;
    logic        beat_take;

    assign accept_mem        = (state == IDLE) & ARBITER_MEM_raddr_valid;
    assign accept_ifu        = (state == IDLE) & ARBITER_IFU_raddr_valid & ~ARBITER_MEM_raddr_valid;
    assign owner_rdata_ready = (owner == OWNER_IFU) ? ARBITER_IFU_rdata_ready : ARBITER_MEM_rdata_ready;
    assign owner_id          = (owner == OWNER_IFU) ? ARID_IFU : ARID_MEM;
    assign beat_take         = (state == R) & io_master_rvalid;

    // Next-state logic for the four-phase transaction sequence
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_mem | accept_ifu) state_nxt = AR;
            AR:      if (io_master_arready)       state_nxt = R;
            R:       if (io_master_rvalid)        state_nxt = RESP;
            RESP:    if (owner_rdata_ready)       state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch owner, address and size of the winning request; held through AR/R/RESP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner    <= OWNER_MEM;
            addr_lat <= 32'h0;
            size_lat <= 3'b000;
        end else if (accept_mem) begin
            owner    <= OWNER_MEM;
            addr_lat <= ARBITER_MEM_raddr;
            size_lat <= ARBITER_MEM_rsize;
        end else if (accept_ifu) begin
            owner    <= OWNER_IFU;
            addr_lat <= ARBITER_IFU_raddr;
            size_lat <= ARBITER_IFU_rsize;
        end
    end

    // Capture the response beat and its error status; error does not alter the flow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_buf <= 64'h0;
            err_flag <= 1'b0;
        end else if (beat_take) begin
            beat_buf <= io_master_rdata;
            err_flag <= beat_is_bad(io_master_rresp, io_master_rid, owner_id, io_master_rlast);
        end
    end

    assign ARBITER_MEM_raddr_ready = accept_mem;
    assign ARBITER_IFU_raddr_ready = accept_ifu;

    assign io_master_arvalid = (state == AR);
    assign io_master_araddr  = addr_lat;
    assign io_master_arsize  = size_lat;
    assign io_master_arid    = owner_id;
    assign io_master_arlen   = AXI_LEN_SINGLE;
    assign io_master_arburst = AXI_BURST_INCR;
    assign io_master_rready  = (state == R);

    // Both masters see the buffer; only the owner sees valid
    assign ARBITER_IFU_rdata       = beat_buf;
    assign ARBITER_MEM_rdata       = beat_buf;
    assign ARBITER_IFU_rdata_valid = (state == RESP) & (owner == OWNER_IFU);
    assign ARBITER_MEM_rdata_valid = (state == RESP) & (owner == OWNER_MEM);

    assign ARBITER_error_signal = err_flag;

endmodule
